// File: rtl/sun_pll_divn_lock.sv
// Programmable divide-by-N PLL feedback divider with a reference-period frequency-lock detector.
// Single VCO clock domain; CK_REF is treated as asynchronous data through a 2-flop synchronizer.
module sun_pll_divn_lock #(
    parameter int W        = 8,
    parameter int DIV_RST  = 32,
    parameter int CW       = 10,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         PWRUP_1V8,
    input  logic [W-1:0] DIV,
    input  logic         DIV_LD,
    output logic         DIV_ACK,
    input  logic         DUTY50,
    input  logic         CK_REF,
    output logic         CK_FB,
    output logic         LOCK
);
    localparam int                HW       = $clog2(LOCK_CNT + 1);
    localparam logic [HW-1:0]     HITS_MAX = HW'(LOCK_CNT);
    localparam logic [CW-1:0]     PC_MAX   = '1;
    localparam logic signed [CW:0] TOL_S   = (CW+1)'(TOL);

    logic [W-1:0]  cnt_q, cnt_d, nact_q, nact_d, shadow_q, shadow_d;
    logic [W-1:0]  half, div_c;
    logic          pend_q, pend_d, fb_q, fb_d, ack_q, ack_d;
    logic          lock_q, lock_d, pcv_q, pcv_d;
    logic [CW-1:0] pc_q, pc_d;
    logic [HW-1:0] hits_q, hits_d;
    logic          ref_s1_q, ref_s2_q, ref_s3_q;
    logic          wrap, apply, ref_edge, sat, in_tol;
    logic signed [CW:0] diff;

    assign wrap     = (cnt_q == nact_q - 1'b1);
    assign apply    = wrap & pend_q;
    assign half     = (nact_q >> 1) + W'(nact_q[0]);
    assign div_c    = (DIV < W'(2)) ? W'(2) : DIV;
    assign ref_edge = ref_s2_q & ~ref_s3_q;
    assign sat      = (pc_q == PC_MAX);
    assign diff     = $signed({1'b0, pc_q}) - $signed({1'b0, CW'(nact_q)});
    assign in_tol   = (diff <= TOL_S) && (diff >= -TOL_S);

    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        nact_d   = nact_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        fb_d     = DUTY50 ? (cnt_q < half) : (cnt_q == '0);
        ack_d    = apply;
        pc_d     = ref_edge ? CW'(1) : (sat ? pc_q : pc_q + 1'b1);
        pcv_d    = pcv_q;
        hits_d   = hits_q;
        lock_d   = lock_q;

        // New ratio lands only on a wrap so the old period always completes.
        if (apply) begin
            nact_d = shadow_q;
            pend_d = 1'b0;
        end
        if (DIV_LD) begin
            shadow_d = div_c;
            pend_d   = 1'b1;
        end

        if (apply) begin
            hits_d = '0;
            lock_d = 1'b0;
            pcv_d  = 1'b0;
        end else if (ref_edge) begin
            if (!pcv_q) begin
                pcv_d = 1'b1;
            end else if (in_tol) begin
                hits_d = (hits_q == HITS_MAX) ? hits_q : hits_q + 1'b1;
                lock_d = (hits_d == HITS_MAX);
            end else begin
                hits_d = '0;
                lock_d = 1'b0;
            end
        end else if (sat) begin
            hits_d = '0;
            lock_d = 1'b0;
            pcv_d  = 1'b0;
        end

        if (!PWRUP_1V8) begin
            cnt_d    = '0;
            nact_d   = nact_q;
            shadow_d = shadow_q;
            pend_d   = 1'b0;
            fb_d     = 1'b0;
            ack_d    = 1'b0;
            pc_d     = '0;
            pcv_d    = 1'b0;
            hits_d   = '0;
            lock_d   = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt_q    <= '0;
            nact_q   <= W'(DIV_RST);
            shadow_q <= W'(DIV_RST);
            pend_q   <= 1'b0;
            fb_q     <= 1'b0;
            ack_q    <= 1'b0;
            lock_q   <= 1'b0;
            pc_q     <= '0;
            pcv_q    <= 1'b0;
            hits_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            nact_q   <= nact_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            fb_q     <= fb_d;
            ack_q    <= ack_d;
            lock_q   <= lock_d;
            pc_q     <= pc_d;
            pcv_q    <= pcv_d;
            hits_q   <= hits_d;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            ref_s1_q <= 1'b0;
            ref_s2_q <= 1'b0;
            ref_s3_q <= 1'b0;
        end else begin
            ref_s1_q <= CK_REF;
            ref_s2_q <= ref_s1_q;
            ref_s3_q <= ref_s2_q;
        end
    end

    assign CK_FB   = fb_q;
    assign DIV_ACK = ack_q;
    assign LOCK    = lock_q;
endmodule

// File: tb/tb_sun_pll_divn_lock.sv
// Bench for sun_pll_divn_lock: directed scenarios plus random traffic against a cycle-level model
// that tracks period position and the cycle stamp of the last reference edge.
module tb_sun_pll_divn_lock;
    localparam int W = 8, TOL = 1, LCNT = 4, PCMAX = 1023;

    logic         CK = 1'b0, RN = 1'b0, PWRUP_1V8 = 1'b0;
    logic         DIV_LD = 1'b0, DUTY50 = 1'b0, CK_REF = 1'b0;
    logic [W-1:0] DIV = '0;
    logic         DIV_ACK, CK_FB, LOCK;

    sun_pll_divn_lock dut (
        .CK(CK), .RN(RN), .PWRUP_1V8(PWRUP_1V8), .DIV(DIV), .DIV_LD(DIV_LD),
        .DIV_ACK(DIV_ACK), .DUTY50(DUTY50), .CK_REF(CK_REF), .CK_FB(CK_FB), .LOCK(LOCK)
    );

    always #5 CK = ~CK;

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    int m_pos, m_n, m_shadow, m_pend, m_fb, m_ack, m_lock, m_hits, m_valid;
    int m_t = 0, m_e = 0;
    int m_hist[3];

    task automatic model_reset();
        m_pos = 0; m_n = 32; m_shadow = 32; m_pend = 0;
        m_fb = 0; m_ack = 0; m_lock = 0; m_hits = 0; m_valid = 0;
        m_e = m_t;
        m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
    endtask

    task automatic model_step();
        int pc, ev, wrap, apply, d;
        pc = m_t - m_e;
        if (pc > PCMAX) pc = PCMAX;
        ev = (m_hist[1] == 1 && m_hist[2] == 0);
        m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = int'(CK_REF);
        if (!PWRUP_1V8) begin
            m_pos = 0; m_fb = 0; m_pend = 0; m_ack = 0;
            m_e = m_t + 1; m_valid = 0; m_hits = 0; m_lock = 0;
        end else begin
            wrap  = (m_pos == m_n - 1);
            apply = wrap && m_pend;
            m_fb  = DUTY50 ? (m_pos < (m_n + 1) / 2) : (m_pos == 0);
            m_ack = apply;
            m_pos = wrap ? 0 : m_pos + 1;
            if (ev) m_e = m_t;
            if (apply) begin
                m_n = m_shadow; m_pend = 0; m_hits = 0; m_lock = 0; m_valid = 0;
            end else if (ev) begin
                if (!m_valid) m_valid = 1;
                else begin
                    d = pc - m_n;
                    if (d <= TOL && d >= -TOL) begin
                        m_hits = (m_hits < LCNT) ? m_hits + 1 : LCNT;
                        m_lock = (m_hits == LCNT);
                    end else begin
                        m_hits = 0; m_lock = 0;
                    end
                end
            end else if (pc == PCMAX) begin
                m_hits = 0; m_lock = 0; m_valid = 0;
            end
            if (DIV_LD) begin
                m_shadow = (int'(DIV) < 2) ? 2 : int'(DIV);
                m_pend = 1;
            end
        end
        m_t++;
    endtask

    int ref_per = 0, ref_ph = 0;
    int n_ack = 0, n_fb = 0, lock_seen = 0;

    task automatic set_ref(input int p);
        ref_per = p; ref_ph = 0;
    endtask

    // One CK: drive reference, clock, advance model, then compare away from the edge.
    task automatic cyc();
        if (ref_per < 2) CK_REF = 1'b0;
        else begin
            CK_REF = (ref_ph < ref_per / 2);
            ref_ph = (ref_ph + 1) % ref_per;
        end
        @(posedge CK);
        if (RN) model_step();
        #1;
        chk("ck_fb", CK_FB, m_fb);
        chk("div_ack", DIV_ACK, m_ack);
        chk("lock", LOCK, m_lock);
        if (DIV_ACK) n_ack++;
        if (CK_FB) n_fb++;
        if (LOCK) lock_seen = 1;
    endtask

    task automatic load(input int v);
        DIV = W'(v); DIV_LD = 1'b1;
        cyc();
        DIV_LD = 1'b0;
    endtask

    initial begin
        int got, pwr_off;
        model_reset();
        #23;
        chk("rst_fb", CK_FB, 0);
        chk("rst_ack", DIV_ACK, 0);
        chk("rst_lock", LOCK, 0);
        @(posedge CK); #1;
        RN = 1'b1; PWRUP_1V8 = 1'b1;

        // default ratio, pulse mode
        n_fb = 0; n_ack = 0; lock_seen = 0;
        repeat (96) cyc();
        chk("pulses_96", n_fb, 3);
        chk("no_ack", n_ack, 0);
        chk("no_lock", lock_seen, 0);
        repeat (4) cyc();

        // back-to-back loads: last value wins, single ack
        n_ack = 0;
        load(7);
        repeat (5) cyc();
        load(9);
        repeat (80) cyc();
        chk("acks_7_9", n_ack, 1);

        DUTY50 = 1'b1;
        load(5);  repeat (40) cyc();
        load(2);  repeat (20) cyc();
        n_ack = 0;
        load(1);  repeat (20) cyc();
        chk("acks_div1", n_ack, 1);

        // lock scenarios at N=40
        DUTY50 = 1'b0;
        load(40); repeat (100) cyc();
        set_ref(40); repeat (400) cyc();
        chk("lock_p40", LOCK, 1);
        set_ref(42); repeat (100) cyc();
        lock_seen = 0;
        repeat (300) cyc();
        chk("lock_p42", lock_seen, 0);
        set_ref(41); repeat (400) cyc();
        chk("lock_p41", LOCK, 1);
        set_ref(0); repeat (1100) cyc();
        chk("lock_noref", LOCK, 0);

        // ratio change while locked
        set_ref(41); repeat (400) cyc();
        chk("lock_relock", LOCK, 1);
        load(20);
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            cyc();
            if (DIV_ACK) begin
                got = 1;
                chk("lock_at_ack", LOCK, 0);
            end
        end
        chk("ack_seen", got, 1);

        // power-down while locked
        set_ref(20); repeat (300) cyc();
        chk("lock_n20", LOCK, 1);
        PWRUP_1V8 = 1'b0;
        repeat (5) cyc();
        chk("pwr_fb", CK_FB, 0);
        chk("pwr_lock", LOCK, 0);
        PWRUP_1V8 = 1'b1;
        repeat (300) cyc();

        // random traffic
        pwr_off = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pwr_off > 0) begin
                pwr_off--;
                if (pwr_off == 0) PWRUP_1V8 = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                PWRUP_1V8 = 1'b0;
                pwr_off = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 99) == 0) DUTY50 = ~DUTY50;
            if ($urandom_range(0, 399) == 0)
                set_ref(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 70))
                                                    : m_n - 1 + int'($urandom_range(0, 2)));
            DIV = W'($urandom_range(0, 60));
            DIV_LD = ($urandom_range(0, 39) == 0);
            cyc();
        end
        DIV_LD = 1'b0; PWRUP_1V8 = 1'b1;

        // async reset mid-period
        repeat (7) cyc();
        RN = 1'b0;
        model_reset();
        #1;
        chk("rn_fb", CK_FB, 0);
        chk("rn_ack", DIV_ACK, 0);
        chk("rn_lock", LOCK, 0);
        repeat (3) cyc();
        RN = 1'b1;
        set_ref(0);
        DUTY50 = 1'b0;
        n_fb = 0;
        repeat (64) cyc();
        chk("pulses_after_rn", n_fb, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sun_pll_divn_lock.md
# sun_pll_divn_lock

Programmable feedback divider with integrated frequency-lock detector for the SUN PLL, running in the VCO clock domain. Replaces the fixed divide-by-32 ripple feedback divider with a synchronous divide-by-N counter. N changes glitch-free on period boundaries, and the output duty cycle is selectable. The block also measures the reference period in VCO cycles and asserts LOCK after a programmable run of in-tolerance reference periods.

## Interface
Parameters:
- W, 8, divide-ratio width; N range 2..2^W-1
- DIV_RST, 32, ratio loaded at reset
- CW, 10, reference-period counter width; CW > W required
- TOL, 1, lock tolerance in VCO cycles (absorbs synchronizer ±1 jitter)
- LOCK_CNT, 4, consecutive in-tolerance reference periods needed for LOCK (≥1)

Ports:
- CK  in  1  VCO clock, the only clock
- RN  in  1  reset, asynchronous, active-low
- PWRUP_1V8  in  1  synchronous enable; low holds divider and detector cleared
- DIV  in  W  requested ratio; 0 and 1 coerced to 2 at capture
- DIV_LD  in  1  load request, sampled every CK
- DIV_ACK  out  1  one-cycle pulse when the new ratio takes effect
- DUTY50  in  1  1 = near-50 % output, 0 = single-cycle pulse
- CK_REF  in  1  reference clock, asynchronous, sampled as data
- CK_FB  out  1  divided clock, registered
- LOCK  out  1  frequency-lock flag, registered

## Operation
- State: cnt (W bits, 0..Nact-1), Nact, shadow, pending, ref_s1/ref_s2/ref_s3, pc (CW), pc_valid, hits (0..LOCK_CNT).
- Reset (RN low): cnt=0, Nact=DIV_RST, shadow=DIV_RST, pending=0, CK_FB=0, DIV_ACK=0, LOCK=0, pc=0, pc_valid=0, hits=0, sync flops=0.
- PWRUP_1V8=0: synchronously clear cnt, CK_FB, pending, DIV_ACK, pc, pc_valid, hits, LOCK. Nact is kept.
- Divider: cnt increments each CK and wraps at Nact-1→0.
  - Pulse mode: CK_FB <= (cnt==0).
  - DUTY50 mode: CK_FB <= (cnt < ceil(Nact/2)); N=2 gives 1H/1L, N=3 gives 2H/1L.
  - A DUTY50 change takes effect on the next CK.
- Ratio load:
  - DIV_LD=1 writes shadow <= coerced DIV and sets pending=1.
  - Repeated DIV_LD while pending overwrites shadow; last value wins; only one ACK results.
  - On a wrap cycle with pending=1: Nact <= shadow, pending <= 0, DIV_ACK=1 for that cycle, hits <= 0, LOCK <= 0.
  - DIV_LD coinciding with a wrap is captured but not applied until the following wrap.
- Lock detect:
  - CK_REF goes through a 2-flop synchronizer (ref_s1, ref_s2). ref_s3 delays ref_s2 by one CK. Rising edge = ref_s2 & ~ref_s3.
  - pc counts CK cycles since the last edge and saturates at 2^CW-1. On an edge, pc <= 1.
  - First edge after reset, power-up or ratio change: pc_valid <= 1, no evaluation.
  - Edge with pc_valid: if |pc − Nact| ≤ TOL, hits <= min(hits+1, LOCK_CNT); otherwise hits <= 0 and LOCK <= 0.
  - LOCK <= 1 when hits reaches LOCK_CNT and stays 1 until a miss, pc saturation, ratio change or disable.
  - pc saturation (no reference): hits <= 0, LOCK <= 0, pc_valid <= 0.
- Ratio update and reference edge in the same cycle: the ratio update wins; hits is cleared and pc_valid <= 0.

## Timing
- All outputs are registered; CK_FB toggles on CK rising edges only.
- CK_FB latency: one CK after cnt. First pulse-mode high occurs 1 CK after PWRUP_1V8 rises.
- CK_FB period = Nact CK cycles exactly, including across a ratio change: the old period completes, then the new one starts. No runt or stretched pulse is allowed.
- DIV_ACK is high in the same cycle Nact updates.
- Edge detection latency: 3 CK from the CK_REF transition.
- LOCK rises 1 CK after the LOCK_CNT-th in-tolerance edge is detected and falls 1 CK after the disqualifying event.
- RN deassertion must be synchronized externally to CK; the block does not resynchronize RN.

## Test plan
- Reset, DUTY50=0, PWRUP_1V8=1: CK_FB pulses 1 cycle every 32 CK; DIV_ACK, LOCK stay 0 with CK_REF idle.
- DUTY50=1 with N=5 loaded: CK_FB 3H/2L. Load N=2: 1H/1L. Load DIV=1: behaves as N=2 and DIV_ACK pulses once.
- DIV_LD=7 mid-period from N=32, then DIV_LD=9 before the wrap: the current 32-cycle period completes, one DIV_ACK, then a 9-cycle period follows; no intermediate 7-cycle period appears.
- CK_REF period 40 CK, N=40: LOCK rises after the 5th reference edge (1 priming + 4 hits). Period 42: LOCK stays 0. Period 41: LOCK asserts (TOL=1).
- While locked, stop CK_REF: LOCK falls when pc reaches 1023. While locked, load N=20: LOCK drops in the ACK cycle.
- Assert RN low mid-period and PWRUP_1V8 low mid-lock: all outputs clear as specified. After RN release, Nact=32. After PWRUP_1V8 toggle, Nact keeps its previous value.
